multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM that sequences the shared datapath (PC, IR, register file, ALU, immediate generator, data memory) over several cycles per RV32I instruction.
- Handles fetch and load/store handshakes with instruction and data memory, and bus timeouts.
- Decodes opcode classes to steer datapath muxes, and counts retired instructions.
- Sits between the memory interfaces and the datapath mux/enable controls.

Parameters:
- TIMEOUT, 16, max wait cycles for an ack in FETCH or MEM before trapping (≥2).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  instr[6:0] from IR; valid from DECODE onward.
- branch_taken  input  1  ALU compare result; sampled in EXEC for branches.
- imem_ack  input  1  instruction memory data valid; IR loads this cycle.
- dmem_ack  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  store (valid with dmem_req).
- ir_we  output  1  load IR.
- pc_we  output  1  update PC.
- pc_sel  output  2  00 PC+4, 01 PC+imm, 10 ALU result.
- rf_we  output  1  register file write.
- wb_sel  output  2  00 ALU, 01 mem data, 10 PC+4, 11 imm.
- alu_src_a  output  1  0 rs1, 1 PC.
- alu_src_b  output  1  0 rs2, 1 imm.
- trap  output  1  sticky error flag.
- trap_cause  output  2  00 none, 01 illegal opcode, 10 bus timeout.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- States: START, FETCH, DECODE, EXEC, MEM, WB, TRAP. One transition per clk.
- Reset (async, rst_n=0):
  - state=START, opcode_q=0, wait counter=0.
  - retired=0, trap=0, trap_cause=00.
  - All strobes (imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we)=0; all selects=0.
- START: no strobes; go to FETCH next cycle.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On ack: ir_we=1 same cycle; go to DECODE; counter cleared.
  - Without ack: counter increments. If counter==TIMEOUT-1 and no ack: go to TRAP with cause 10.
- DECODE:
  - Latch opcode into opcode_q.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode: go to TRAP with cause 01. Otherwise go to EXEC.
- EXEC selects, from opcode_q:
  - alu_src_b=1 for I-ALU, load, store, JALR, AUIPC.
  - alu_src_a=1 for AUIPC only.
- EXEC next state:
  - Branch: pc_we=1; pc_sel=01 if branch_taken else 00; go to FETCH (retires here).
  - Load/store: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1 held until dmem_ack; dmem_we=1 for store; alu_src_b=1 held stable.
  - On ack, store: pc_we=1, pc_sel=00, go to FETCH (retires).
  - On ack, load: go to WB.
  - Timeout: same counter rule as FETCH; go to TRAP with cause 10.
- WB: rf_we=1, pc_we=1 in the same cycle; go to FETCH (retires).
  - R / I-ALU / AUIPC: wb_sel=00, pc_sel=00.
  - Load: wb_sel=01, pc_sel=00.
  - LUI: wb_sel=11, pc_sel=00.
  - JAL: wb_sel=10, pc_sel=01.
  - JALR: wb_sel=10, pc_sel=10 (datapath clears bit 0).
- TRAP:
  - All strobes 0; trap=1 and trap_cause held until rst_n low.
  - Acks arriving in TRAP are ignored.
- Retirement: retired increments by 1 on each retire cycle and wraps from all-ones to 0. It never increments in TRAP.
- Selects: only meaningful in the states named above; drive 0 elsewhere.
- Ack timing:
  - An ack arriving in the same cycle the counter hits TIMEOUT-1 wins; no trap.
  - Acks outside FETCH/MEM are ignored.
- Reset mid-operation: immediate return to START; no partial rf_we or pc_we is issued after rst_n deasserts.
- Latency with zero-wait acks (ack in the first request cycle):
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
- Reset then ADDI (0010011), imem_ack in 1st FETCH cycle -> rf_we=1 with alu_src_b=1 and wb_sel=00 in cycle 4 after START; retired=1.
- Load (0000011), dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, dmem_we=0, then WB with wb_sel=01; retired=1.
- Branch (1100011): branch_taken=1 -> pc_sel=01 with pc_we in EXEC; branch_taken=0 -> pc_sel=00; rf_we never asserted; retired +1 each.
- Opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=01; further imem_ack pulses cause no strobes; rst_n low clears trap.
- TIMEOUT=4, imem_ack never arrives -> imem_req high 4 cycles then TRAP, trap_cause=10; separately, ack on 4th cycle -> no trap, DECODE follows.
- JAL then JALR back-to-back -> WB shows wb_sel=10 with pc_sel=01, then wb_sel=10 with pc_sel=10; rst_n pulsed mid-MEM of a store -> no pc_we, state restarts via START.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and the
// instruction/data memory ports.
interface multicycle_controller_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback over
// a shared datapath, supervises memory handshakes with a timeout, counts retires.
module multicycle_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus,
    input  logic [6:0]              opcode,
    input  logic                    branch_taken,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic [1:0]              pc_sel,
    output logic                    rf_we,
    output logic [1:0]              wb_sel,
    output logic                    alu_src_a,
    output logic                    alu_src_b,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [CNT_W-1:0]        retired
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_R       = 4'd0,
        CL_IALU    = 4'd1,
        CL_LOAD    = 4'd2,
        CL_STORE   = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_JAL     = 4'd5,
        CL_JALR    = 4'd6,
        CL_LUI     = 4'd7,
        CL_AUIPC   = 4'd8,
        CL_ILLEGAL = 4'd9
    } iclass_t;

    function automatic iclass_t decode_class(input logic [6:0] op);
        iclass_t cls;
        case (op)
            7'b0110011: cls = CL_R;
            7'b0010011: cls = CL_IALU;
            7'b0000011: cls = CL_LOAD;
            7'b0100011: cls = CL_STORE;
            7'b1100011: cls = CL_BRANCH;
            7'b1101111: cls = CL_JAL;
            7'b1100111: cls = CL_JALR;
            7'b0110111: cls = CL_LUI;
            7'b0010111: cls = CL_AUIPC;
            default:    cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [6:0]        opcode_q_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic              trap_r;
    logic [1:0]        trap_cause_r;
    logic              trap_set_s;
    logic [1:0]        trap_cause_s;
    logic              retire_s;
    logic [CNT_W-1:0]  retired_r;
    logic              imem_req_s;
    logic              dmem_req_s;
    logic              dmem_we_s;
    logic              src_a_s;
    logic              src_b_s;
    iclass_t           cls_dec_s;
    iclass_t           cls_q_s;

    assign cls_dec_s = decode_class(opcode);
    assign cls_q_s   = decode_class(opcode_q_r);

    // Operand selects by class; held through EXEC and WB so the ALU result stays stable.
    always_comb begin
        src_a_s = (cls_q_s == CL_AUIPC);
        src_b_s = (cls_q_s == CL_IALU) || (cls_q_s == CL_LOAD) || (cls_q_s == CL_STORE) ||
                  (cls_q_s == CL_JALR) || (cls_q_s == CL_AUIPC);
    end

    // Next-state, handshake strobes, datapath selects and retire/trap events.
    always_comb begin
        state_s      = state_r;
        wait_cnt_s   = {WAIT_W{1'b0}};
        trap_set_s   = 1'b0;
        trap_cause_s = 2'b00;
        retire_s     = 1'b0;
        imem_req_s   = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        case (state_r)
            ST_START: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (bus.imem_ack) begin
                    ir_we   = 1'b1;
                    state_s = ST_DECODE;
                end else if (wait_cnt_r == WAIT_MAX) begin
                    state_s      = ST_TRAP;
                    trap_set_s   = 1'b1;
                    trap_cause_s = 2'b10;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (cls_dec_s == CL_ILLEGAL) begin
                    state_s      = ST_TRAP;
                    trap_set_s   = 1'b1;
                    trap_cause_s = 2'b01;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_a = src_a_s;
                alu_src_b = src_b_s;
                if (cls_q_s == CL_BRANCH) begin
                    pc_we    = 1'b1;
                    pc_sel   = branch_taken ? 2'b01 : 2'b00;
                    retire_s = 1'b1;
                    state_s  = ST_FETCH;
                end else if ((cls_q_s == CL_LOAD) || (cls_q_s == CL_STORE)) begin
                    state_s = ST_MEM;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_q_s == CL_STORE);
                alu_src_b  = 1'b1;
                if (bus.dmem_ack) begin
                    if (cls_q_s == CL_STORE) begin
                        pc_we    = 1'b1;
                        retire_s = 1'b1;
                        state_s  = ST_FETCH;
                    end else begin
                        state_s = ST_WB;
                    end
                end else if (wait_cnt_r == WAIT_MAX) begin
                    state_s      = ST_TRAP;
                    trap_set_s   = 1'b1;
                    trap_cause_s = 2'b10;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                retire_s  = 1'b1;
                alu_src_a = src_a_s;
                alu_src_b = src_b_s;
                state_s   = ST_FETCH;
                case (cls_q_s)
                    CL_LOAD: begin
                        wb_sel = 2'b01;
                        pc_sel = 2'b00;
                    end
                    CL_LUI: begin
                        wb_sel = 2'b11;
                        pc_sel = 2'b00;
                    end
                    CL_JAL: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b01;
                    end
                    CL_JALR: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b10;
                    end
                    default: begin
                        wb_sel = 2'b00;
                        pc_sel = 2'b00;
                    end
                endcase
            end
            ST_TRAP: begin
                state_s = ST_TRAP;
            end
            default: begin
                state_s = ST_START;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_START;
        end else begin
            state_r <= state_s;
        end
    end

    // Opcode capture in DECODE so later states decode from a stable copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q_r <= 7'd0;
        end else if (state_r == ST_DECODE) begin
            opcode_q_r <= opcode;
        end
    end

    // Handshake wait counter, shared by FETCH and MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Sticky trap flag and cause; only reset can clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_r       <= 1'b0;
            trap_cause_r <= 2'b00;
        end else if (trap_set_s) begin
            trap_r       <= 1'b1;
            trap_cause_r <= trap_cause_s;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end
    end

    assign bus.imem_req = imem_req_s;
    assign bus.dmem_req = dmem_req_s;
    assign bus.dmem_we  = dmem_we_s;
    assign trap         = trap_r;
    assign trap_cause   = trap_cause_r;
    assign retired      = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words
// are queued alongside stimulus and compared against the DUT each cycle.
module tb_multicycle_controller;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [14:0] IREQ = 15'h4000;
    localparam logic [14:0] DREQ = 15'h2000;
    localparam logic [14:0] DWE  = 15'h1000;
    localparam logic [14:0] IRWE = 15'h0800;
    localparam logic [14:0] PCWE = 15'h0400;
    localparam logic [14:0] RFWE = 15'h0080;
    localparam logic [14:0] SA   = 15'h0010;
    localparam logic [14:0] SB   = 15'h0008;
    localparam logic [14:0] TRP  = 15'h0004;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          branch_taken = 1'b0;
    logic          ir_we, pc_we, rf_we, alu_src_a, alu_src_b, trap;
    logic [1:0]    pc_sel, wb_sel, trap_cause;
    logic [CW-1:0] retired;

    multicycle_controller_if bus ();

    multicycle_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [9:0]    stim_q[$];
    logic [18:0]   exp_q[$];
    logic [CW-1:0] model_ret = '0;

    function automatic logic [14:0] ps(input logic [1:0] v);
        return {5'b0, v, 8'b0};
    endfunction

    function automatic logic [14:0] ws(input logic [1:0] v);
        return {8'b0, v, 5'b0};
    endfunction

    function automatic logic [14:0] cs(input logic [1:0] v);
        return {13'b0, v};
    endfunction

    function automatic logic [18:0] observe();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, pc_sel, rf_we,
                wb_sel, alu_src_a, alu_src_b, trap, trap_cause, retired};
    endfunction

    task automatic push(input logic [14:0] ctl, input logic [6:0] op, input logic tk,
                        input logic ia, input logic da, input logic ret);
        stim_q.push_back({op, tk, ia, da});
        exp_q.push_back({ctl, model_ret});
        if (ret) model_ret = model_ret + 4'd1;
    endtask

    task automatic play(output logic [18:0] obs);
        logic [9:0] s;
        s = stim_q.pop_front();
        {opcode, branch_taken, bus.imem_ack, bus.dmem_ack} = s;
        @(negedge clk);
        obs = observe();
        @(posedge clk);
        #1;
    endtask

    // Expected cycle sequence for one instruction, starting in FETCH.
    task automatic add_instr(input logic [6:0] op, input logic tk, input int iw, input int dw);
        logic ld, st, a, b;
        logic [1:0] wsv, psv;
        ld = (op == OP_LD);
        st = (op == OP_ST);
        a  = (op == OP_AUIPC);
        b  = (op == OP_I) || ld || st || (op == OP_JALR) || a;
        for (int k = 0; k < iw; k++) push(IREQ, op, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IREQ | IRWE, op, 1'b0, 1'b1, 1'b0, 1'b0);
        push(15'd0, op, 1'b0, 1'b0, 1'b0, 1'b0);
        if (op == OP_BR) begin
            push(PCWE | ps(tk ? 2'b01 : 2'b00), op, tk, 1'b0, 1'b0, 1'b1);
        end else begin
            push((a ? SA : 15'd0) | (b ? SB : 15'd0), op, 1'b0, 1'b0, 1'b0, 1'b0);
            if (ld || st) begin
                for (int k = 0; k < dw; k++) push(DREQ | (st ? DWE : 15'd0) | SB, op, 1'b0, 1'b0, 1'b0, 1'b0);
                push(DREQ | (st ? (DWE | PCWE) : 15'd0) | SB, op, 1'b0, 1'b0, 1'b1, st);
            end
            if (!st) begin
                wsv = 2'b00; psv = 2'b00;
                if (ld) wsv = 2'b01;
                if (op == OP_LUI) wsv = 2'b11;
                if (op == OP_JAL) begin wsv = 2'b10; psv = 2'b01; end
                if (op == OP_JALR) begin wsv = 2'b10; psv = 2'b10; end
                push(RFWE | PCWE | ws(wsv) | ps(psv) | (a ? SA : 15'd0) | (b ? SB : 15'd0),
                     op, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
    endtask

    task automatic reset_pulse(output logic [18:0] obs);
        rst_n = 1'b0;
        opcode = 7'd0; branch_taken = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        #1;
        obs = observe();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ret = '0;
        push(15'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [18:0] obs, e;
        int n = 0;
        @(posedge clk);
        #1;
        reset_pulse(obs);
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL reset_vals got=%h exp=%h", obs, 19'd0); end
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_start cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_alu();
        logic [18:0] obs, e;
        int n = 0;
        add_instr(OP_I, 1'b0, 0, 0);
        add_instr(OP_R, 1'b0, 2, 0);
        add_instr(OP_LUI, 1'b0, 0, 0);
        add_instr(OP_AUIPC, 1'b0, 1, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL alu cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_load_store();
        logic [18:0] obs, e;
        int n = 0;
        add_instr(OP_LD, 1'b0, 0, 3);
        add_instr(OP_ST, 1'b0, 0, 0);
        add_instr(OP_ST, 1'b0, 1, 3);
        add_instr(OP_LD, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL ldst cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_branch();
        logic [18:0] obs, e;
        int n = 0;
        add_instr(OP_BR, 1'b1, 0, 0);
        add_instr(OP_BR, 1'b0, 0, 0);
        add_instr(OP_BR, 1'b1, 2, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL branch cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_fetch_edge();
        logic [18:0] obs, e;
        int n = 0;
        add_instr(OP_I, 1'b0, TO - 1, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL ack_edge cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] obs, e;
        int n = 0;
        add_instr(OP_JAL, 1'b0, 0, 0);
        add_instr(OP_JALR, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL jal_jalr cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_retire_wrap();
        logic [18:0] obs, e;
        int n = 0;
        for (int i = 0; i < 18; i++) add_instr(OP_BR, 1'(i % 2), 0, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL wrap cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_illegal();
        logic [18:0] obs, e;
        int n = 0;
        push(IREQ | IRWE, OP_BAD, 1'b0, 1'b1, 1'b0, 1'b0);
        push(15'd0, OP_BAD, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) push(TRP | cs(2'b01), OP_BAD, 1'b0, 1'(k % 2), 1'(k / 2), 1'b0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL illegal cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
        reset_pulse(obs);
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL trap_clear got=%h exp=%h", obs, 19'd0); end
        add_instr(OP_I, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL post_trap cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_timeout();
        logic [18:0] obs, e;
        int n = 0;
        for (int k = 0; k < TO; k++) push(IREQ, OP_I, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) push(TRP | cs(2'b10), OP_I, 1'b0, 1'b1, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL fetch_to cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
        reset_pulse(obs);
        push(IREQ | IRWE, OP_ST, 1'b0, 1'b1, 1'b0, 1'b0);
        push(15'd0, OP_ST, 1'b0, 1'b0, 1'b0, 1'b0);
        push(SB, OP_ST, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < TO; k++) push(DREQ | DWE | SB, OP_ST, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) push(TRP | cs(2'b10), OP_ST, 1'b0, 1'b0, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL mem_to cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
        reset_pulse(obs);
        add_instr(OP_I, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL post_to cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [18:0] obs, e;
        int n = 0;
        push(IREQ | IRWE, OP_ST, 1'b0, 1'b1, 1'b0, 1'b0);
        push(15'd0, OP_ST, 1'b0, 1'b0, 1'b0, 1'b0);
        push(SB, OP_ST, 1'b0, 1'b0, 1'b0, 1'b0);
        push(DREQ | DWE | SB, OP_ST, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL pre_rst cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
        opcode = OP_ST; bus.dmem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        obs = observe(); checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL mid_rst got=%h exp=%h", obs, 19'd0); end
        @(posedge clk);
        #1;
        obs = observe(); checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL mid_rst_hold got=%h exp=%h", obs, 19'd0); end
        rst_n = 1'b1;
        model_ret = '0;
        push(15'd0, OP_ST, 1'b0, 1'b0, 1'b1, 1'b0);
        add_instr(OP_I, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            play(obs); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL post_rst cyc=%0d got=%h exp=%h", n, obs, e); end
            n++;
        end
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_fetch_edge();
        test_back_to_back();
        test_retire_wrap();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
